counter_ctrl: RTL

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/counter_ctrl.sv
// Start/stop/pause period counter: counts 0..period_q, pulses tick on each wrap,
// and is either one-shot (stops in DONE) or periodic (reloads and keeps running).
module counter_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] value,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done,
  output logic             tick,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           st, st_d;
  logic [WIDTH-1:0] value_d, period_q, period_d;
  logic             mode_q, mode_d, tick_d, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= IDLE;
      value    <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      tick     <= 1'b0;
      err      <= 1'b0;
    end else begin
      st       <= st_d;
      value    <= value_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      tick     <= tick_d;
      err      <= err_d;
    end
  end

  // Priority: stop > start > pause > terminal count.
  always_comb begin
    st_d     = st;
    value_d  = value;
    period_d = period_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    err_d    = 1'b0;
    if (stop) begin
      st_d    = IDLE;
      value_d = '0;
    end else begin
      case (st)
        IDLE, DONE: begin
          if (start) begin
            if (period != '0) begin
              period_d = period;
              mode_d   = mode;
              value_d  = '0;
              st_d     = RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        RUN, HOLD: begin
          // Releasing pause counts on that same edge, so no value repeats.
          if (pause) begin
            st_d = HOLD;
          end else if (value == period_q) begin
            value_d = '0;
            tick_d  = 1'b1;
            st_d    = mode_q ? RUN : DONE;
          end else begin
            value_d = WIDTH'(value + 1'b1);
            st_d    = RUN;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  assign state = st;
  assign busy  = (st == RUN) || (st == HOLD);
  assign done  = (st == DONE);

endmodule
